ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 11, RAM address width.
REQ-002 SHALL have parameter RAM_WAIT, default 1, extra strobe-low cycles per byte access (range 0..7).
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wreq  input  1  write request from the convolution writer; held until wack.
REQ-006 waddr  input  AW  write word address.
REQ-007 wdata  input  16  write word (result).
REQ-008 wack  output  1  one-cycle pulse: write complete.
REQ-009 rreq  input  1  read request from readback port; held until rvalid.
REQ-010 raddr  input  AW  read word address.
REQ-011 rdata  output  16  read word; valid while rvalid is high, then held.
REQ-012 rvalid  output  1  one-cycle pulse: rdata valid.
REQ-013 address  output  AW  RAM address.
REQ-014 outdata  output  8  byte driven to RAM on writes.
REQ-015 indata  input  8  byte returned by RAM on reads.
REQ-016 wr  output  1  RAM write strobe, active low.
REQ-017 rd  output  1  RAM read strobe, active low.
REQ-018 enout1  output  1  low-byte RAM chip select, active low.
REQ-019 enout2  output  1  high-byte RAM chip select, active low.
REQ-020 busy  output  1  high from accept edge until the ack/rvalid cycle ends.

Function
REQ-021 SHALL be a one-hot FSM: IDLE, LO_SETUP, LO_STB, LO_END, HI_SETUP, HI_STB, HI_END.
REQ-022 IDLE: on a rising edge with a qualifying request, SHALL latch address/data/direction and move to LO_SETUP.
REQ-023 *_SETUP: address and outdata driven, matching chip select low, strobes high; 1 cycle.
REQ-024 *_STB: wr (write) or rd (read) low for RAM_WAIT+1 cycles; read byte sampled from indata on the last STB edge.
REQ-025 *_END: strobe and chip select high; 1 cycle; LO_END->HI_SETUP, HI_END->IDLE.
REQ-026 Low byte SHALL use enout1/wdata[7:0]/rdata[7:0]; high byte SHALL use enout2/wdata[15:8]/rdata[15:8]; address is identical for both bytes.
REQ-027 Never SHALL both chip selects, or both wr and rd, be low at the same time.
REQ-028 wack/rvalid SHALL be high exactly 2*(RAM_WAIT+3)+1 cycles after the accept edge (9 at RAM_WAIT=1), for one cycle.
REQ-029 A request whose ack/rvalid is high in the current cycle SHALL NOT qualify (no double accept).
REQ-030 Request deasserted mid-transaction: transaction SHALL complete and ack anyway.
REQ-031 Simultaneous wreq and rreq without RAM_ARB_RR_EN: write SHALL win; read waits.
REQ-032 Address SHALL pass through unmodified; no wrap or bounds check.

Reset
REQ-033 On reset, immediately: FSM IDLE, address=0, outdata=0, rdata=0, wr=rd=enout1=enout2=1, wack=rvalid=busy=0.
REQ-034 Reset mid-transaction SHALL abort without ack/rvalid; no strobe glitch low on release.

Configuration
REQ-035 With RAM_ARB_RR_EN defined: on simultaneous requests, the requester not granted most recently SHALL win (last-grant flag, reset to "read", so the first contest goes to write).
REQ-036 Without RAM_ARB_RR_EN: fixed write priority per REQ-031; no last-grant flag.

Structure
REQ-037 Package ram_arb_pkg SHALL hold FSM state encodings, AW default and RAM_WAIT default.
REQ-038 Grant selection SHALL be sub-module ram_arb_grant (inputs: wreq, rreq, ack masks, last-grant; output: grant_w, grant_r).

Verification
REQ-039 Write waddr=0x123, wdata=0xBEEF, RAM_WAIT=1 -> RAM byte0[0x123]=0xEF, byte1[0x123]=0xBE; wack exactly 9 cycles after accept.
REQ-040 Read raddr=0x123 after REQ-039 -> rdata=0xBEEF, rvalid 9 cycles after accept; only rd/enout pulses, wr stays 1.
REQ-041 wreq and rreq raised on the same edge, three times back-to-back -> default build: three writes first; RAM_ARB_RR_EN build: W,R,W,R,W,R.
REQ-042 reset asserted during HI_STB of a write -> all strobes high the same cycle, no wack, FSM IDLE.
REQ-043 wreq held high one cycle past wack -> exactly one transaction accepted.
REQ-044 RAM_WAIT=0 and RAM_WAIT=3 -> strobe width 1/4 cycles, ack latency 7/13 cycles; checker confirms no overlapping selects.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the byte-wide RAM arbiter.
// FSM state encodings plus address-width and strobe-wait defaults.
package ram_arb_pkg;

   localparam int AW_DEF       = 11;
   localparam int RAM_WAIT_DEF = 1;

   typedef enum logic [6:0] {
      IDLE     = 7'b0000001,
      LO_SETUP = 7'b0000010,
      LO_STB   = 7'b0000100,
      LO_END   = 7'b0001000,
      HI_SETUP = 7'b0010000,
      HI_STB   = 7'b0100000,
      HI_END   = 7'b1000000
   } state_t;

endpackage

// File: rtl/ram_arb_grant.sv
// Write/read grant selection for the RAM arbiter.
// RAM_ARB_RR_EN selects alternating priority; default is write-first.
module ram_arb_grant (
   input  logic wreq,
   input  logic rreq,
   input  logic wmask,
   input  logic rmask,
   input  logic last_w,
   output logic grant_w,
   output logic grant_r
);

   logic wq;
   logic rq;

   assign wq = wreq & ~wmask;
   assign rq = rreq & ~rmask;

`ifdef RAM_ARB_RR_EN
   assign grant_w = wq & (~rq | ~last_w);
   assign grant_r = rq & (~wq | last_w);
`else
   logic unused_last;
   assign unused_last = last_w;
   assign grant_w = wq;
   assign grant_r = rq & ~wq;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates 16-bit write/read requests onto an 8-bit strobed RAM.
// Define RAM_ARB_RR_EN for round-robin priority on simultaneous requests.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int RAM_WAIT = RAM_WAIT_DEF
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          wreq,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   output logic          wack,
   input  logic          rreq,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata,
   output logic          rvalid,
   output logic [AW-1:0] address,
   output logic [7:0]    outdata,
   input  logic [7:0]    indata,
   output logic          wr,
   output logic          rd,
   output logic          enout1,
   output logic          enout2,
   output logic          busy
);

   state_t        state;
   state_t        nxt;
   logic [AW-1:0] areg;
   logic [15:0]   dreg;
   logic          wdir;
   logic [2:0]    cnt;
   logic          last_w;
   logic          grant_w;
   logic          grant_r;
   logic          accept;
   logic          stb;
   logic          stb_done;
   logic          lo_any;
   logic          hi_any;

   ram_arb_grant u_grant (
      .wreq    (wreq),
      .rreq    (rreq),
      .wmask   (wack),
      .rmask   (rvalid),
      .last_w  (last_w),
      .grant_w (grant_w),
      .grant_r (grant_r)
   );

   // The ack cycle counts as busy, so nothing is accepted during it.
   assign accept = (state == IDLE) & ~wack & ~rvalid
                 & (grant_w | grant_r);
   assign stb      = (state == LO_STB) | (state == HI_STB);
   assign stb_done = cnt == 3'(RAM_WAIT);
   assign lo_any   = (state == LO_SETUP) | (state == LO_STB)
                   | (state == LO_END);
   assign hi_any   = (state == HI_SETUP) | (state == HI_STB)
                   | (state == HI_END);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:     if (accept) nxt = LO_SETUP;
         LO_SETUP: nxt = LO_STB;
         LO_STB:   if (stb_done) nxt = LO_END;
         LO_END:   nxt = HI_SETUP;
         HI_SETUP: nxt = HI_STB;
         HI_STB:   if (stb_done) nxt = HI_END;
         HI_END:   nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         areg   <= '0;
         dreg   <= '0;
         wdir   <= 1'b0;
         cnt    <= '0;
         rdata  <= '0;
         wack   <= 1'b0;
         rvalid <= 1'b0;
      end else begin
         wack   <= (state == HI_END) & wdir;
         rvalid <= (state == HI_END) & ~wdir;
         cnt    <= (stb & ~stb_done) ? cnt + 3'd1 : 3'd0;
         if (accept) begin
            areg <= grant_w ? waddr : raddr;
            dreg <= wdata;
            wdir <= grant_w;
         end
         if (~wdir & stb_done & (state == LO_STB))
            rdata[7:0] <= indata;
         if (~wdir & stb_done & (state == HI_STB))
            rdata[15:8] <= indata;
      end
   end

`ifdef RAM_ARB_RR_EN
   // Cleared to "read" so the first contest goes to the writer.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)       last_w <= 1'b0;
      else if (accept) last_w <= grant_w;
   end
`else
   assign last_w = 1'b0;
`endif

   assign address = areg;
   assign enout1  = ~((state == LO_SETUP) | (state == LO_STB));
   assign enout2  = ~((state == HI_SETUP) | (state == HI_STB));
   assign wr      = ~(stb & wdir);
   assign rd      = ~(stb & ~wdir);
   assign busy    = (state != IDLE) | wack | rvalid;

   always_comb begin
      outdata = 8'h00;
      if (wdir & lo_any) outdata = dreg[7:0];
      if (wdir & hi_any) outdata = dreg[15:8];
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: three arbiters (RAM_WAIT 1, 0, 3) with RAM models.
module tb_ram_arbiter;
   import ram_arb_pkg::*;

   localparam int AW = AW_DEF;
   localparam int N  = 3;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [15:0]   d;
   } ent_t;
   typedef logic [AW-1:0] a3_t [3];
   typedef logic [15:0]   d3_t [3];

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int ndone = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : gi
      localparam int RW  = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      localparam int LAT = 2 * (RW + 3) + 1;

      logic          reset, wreq, rreq, wack, rvalid;
      logic          wr, rd, enout1, enout2, busy;
      logic [AW-1:0] waddr, raddr, address;
      logic [15:0]   wdata, rdata;
      logic [7:0]    outdata, indata;
      logic [7:0]    m0 [2**AW];
      logic [7:0]    m1 [2**AW];
      logic [15:0]   shadow [2**AW];
      ent_t          sb [$];
      int            acc_cyc = 0;
      int            wpul = 0;
      int            rpul = 0;
      int            swid = 0;
      logic          en1_q = 1'b1;
      logic          stb_q = 1'b0;

      ram_arbiter #(.AW(AW), .RAM_WAIT(RW)) dut (
         .CLK     (CLK),
         .reset   (reset),
         .wreq    (wreq),
         .waddr   (waddr),
         .wdata   (wdata),
         .wack    (wack),
         .rreq    (rreq),
         .raddr   (raddr),
         .rdata   (rdata),
         .rvalid  (rvalid),
         .address (address),
         .outdata (outdata),
         .indata  (indata),
         .wr      (wr),
         .rd      (rd),
         .enout1  (enout1),
         .enout2  (enout2),
         .busy    (busy)
      );

      assign indata = (!rd && !enout1) ? m0[address] :
                      (!rd && !enout2) ? m1[address] : 8'h00;

      always @(posedge CLK) begin
         if (!wr && !enout1) m0[address] <= outdata;
         if (!wr && !enout2) m1[address] <= outdata;
      end

      function automatic string pfx(input string s);
         return $sformatf("rw%0d %s", RW, s);
      endfunction

      task automatic check_done();
         ent_t e;
         if (sb.size() == 0) begin
            chk(pfx("unexpected ack"), {wack, rvalid}, 2'b00);
            return;
         end
         e = sb.pop_front();
         chk(pfx("ack kind"), {wack, rvalid, busy}, {e.w, !e.w, 1'b1});
         chk(pfx("ack latency"), cyc - acc_cyc + 1, LAT);
         if (e.w) begin
            chk(pfx("ram bytes"), {m1[e.a], m0[e.a]}, e.d);
            chk(pfx("write pulses"), {wpul[7:0], rpul[7:0]}, 16'h0200);
         end else begin
            chk(pfx("rdata"), rdata, e.d);
            chk(pfx("read pulses"), {wpul[7:0], rpul[7:0]}, 16'h0002);
         end
      endtask

      always @(negedge CLK) begin
         en1_q <= enout1;
         stb_q <= !wr || !rd;
         if (!reset) begin
            if (busy)
               chk(pfx("select overlap"),
                   {!enout1 && !enout2, !wr && !rd}, 2'b00);
            if (!enout1 && en1_q) begin
               acc_cyc <= cyc;
               wpul    <= 0;
               rpul    <= 0;
            end
            if ((!wr || !rd) && !stb_q) begin
               swid <= 1;
               if (!wr) wpul <= wpul + 1;
               else     rpul <= rpul + 1;
               if (sb.size() > 0) chk(pfx("address"), address, sb[0].a);
            end else if (!wr || !rd) begin
               swid <= swid + 1;
            end
            if (wr && rd && stb_q) chk(pfx("strobe width"), swid, RW + 1);
            if (wack || rvalid) check_done();
         end
      end

      task automatic push_w(input logic [AW-1:0] a, input logic [15:0] d);
         sb.push_back('{1'b1, a, d});
         shadow[a] = d;
      endtask

      task automatic push_r(input logic [AW-1:0] a);
         sb.push_back('{1'b0, a, shadow[a]});
      endtask

      task automatic wait_ack(input logic w);
         bit seen = 0;
         for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge CLK);
            seen = w ? wack : rvalid;
         end
         if (!seen) chk(pfx("ack timeout"), 0, 1);
      endtask

      task automatic w_agent(input a3_t a, input d3_t d, input int n);
         for (int k = 0; k < n; k++) begin
            waddr = a[k];
            wdata = d[k];
            wreq  = 1'b1;
            wait_ack(1'b1);
         end
         @(posedge CLK);
         #1 wreq = 1'b0;
      endtask

      task automatic r_agent(input a3_t a, input int n);
         for (int k = 0; k < n; k++) begin
            raddr = a[k];
            rreq  = 1'b1;
            wait_ack(1'b0);
         end
         @(posedge CLK);
         #1 rreq = 1'b0;
      endtask

      task automatic one_w(input logic [AW-1:0] a, input logic [15:0] d);
         a3_t aa;
         d3_t dd;
         aa[0] = a;
         dd[0] = d;
         push_w(a, d);
         w_agent(aa, dd, 1);
      endtask

      task automatic one_r(input logic [AW-1:0] a);
         a3_t aa;
         aa[0] = a;
         push_r(a);
         r_agent(aa, 1);
      endtask

      initial begin
         a3_t  ca;
         a3_t  cr;
         d3_t  cd;
         bit   found;
         int   lows;
         reset = 1'b1;
         wreq  = 1'b0;
         rreq  = 1'b0;
         waddr = '0;
         raddr = '0;
         wdata = '0;
         repeat (2) @(negedge CLK);
         chk(pfx("reset ctl"),
             {wr, rd, enout1, enout2, wack, rvalid, busy}, 7'b1111000);
         chk(pfx("reset address"), address, 0);
         chk(pfx("reset outdata"), outdata, 0);
         chk(pfx("reset rdata"), rdata, 0);
         reset = 1'b0;
         @(negedge CLK);

         one_w(11'h123, 16'hBEEF);
         chk(pfx("byte0 123"), m0[11'h123], 8'hEF);
         chk(pfx("byte1 123"), m1[11'h123], 8'hBE);
         one_r(11'h123);
         one_w(11'h7FF, 16'hFFFF);
         one_w(11'h000, 16'h0000);
         one_w(11'h555, 16'hA55A);
         one_r(11'h7FF);
         one_r(11'h000);
         one_r(11'h555);

         for (int k = 0; k < 3; k++) begin
            ca[k] = 11'h010 + 11'(k);
            cd[k] = 16'($urandom_range(0, 65535));
         end
         cr[0] = 11'h123;
         cr[1] = 11'h7FF;
         cr[2] = 11'h555;
`ifdef RAM_ARB_RR_EN
         for (int k = 0; k < 3; k++) begin
            push_w(ca[k], cd[k]);
            push_r(cr[k]);
         end
`else
         for (int k = 0; k < 3; k++) push_w(ca[k], cd[k]);
         for (int k = 0; k < 3; k++) push_r(cr[k]);
`endif
         fork
            w_agent(ca, cd, 3);
            r_agent(cr, 3);
         join
         chk(pfx("contest drained"), sb.size(), 0);

         waddr = 11'h2AA;
         wdata = 16'h1357;
         wreq  = 1'b1;
         found = 0;
         for (int t = 0; t < 60 && !found; t++) begin
            @(negedge CLK);
            if (!enout2 && !wr) found = 1;
         end
         chk(pfx("reach hi_stb"), found, 1);
         #2 reset = 1'b1;
         #1 chk(pfx("abort ctl"),
                {wr, rd, enout1, enout2, wack, rvalid, busy}, 7'b1111000);
         wreq = 1'b0;
         repeat (3) @(negedge CLK);
         reset = 1'b0;
         lows = 0;
         repeat (20) begin
            @(negedge CLK);
            if (!wr || !rd || !enout1 || !enout2 || busy || wack) lows++;
         end
         chk(pfx("idle after abort"), lows, 0);

         one_w(11'h040, 16'h2468);
         one_r(11'h040);
         one_r(11'h010);
         repeat (3) @(negedge CLK);
         chk(pfx("scoreboard empty"), sb.size(), 0);
         ndone++;
      end
   end

   initial begin
      for (int t = 0; t < 30000 && ndone < N; t++) @(negedge CLK);
      if (ndone < N) chk("run timeout", ndone, N);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
